// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: TX FIFO, launch-sampled bit-rate generator and
// start/data/parity/stop frame sequencer driving the TXD pad and status bits.
module uart_tx_ctrl #(
    parameter int DEPTH       = 4,
    parameter int DIV_B9600   = 5208,
    parameter int DIV_B38400  = 1302,
    parameter int DIV_B115200 = 434,
    parameter bit PARITY_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wdata_valid,
    input  logic [7:0] wdata,
    input  logic [1:0] ctrl_baud,
    input  logic       ctrl_txen,
    input  logic       ctrl_txst,
    input  logic       lpmode_en,
    input  logic [7:0] lpmode_div,
    output logic       txd,
    output logic       stat_busy,
    output logic       stat_txf,
    output logic       intstat_tx,
    output logic       tx_ovf
);

    localparam int DIV_MAX_A = (DIV_B9600 > DIV_B38400) ? DIV_B9600 : DIV_B38400;
    localparam int DIV_MAX   = (DIV_MAX_A > DIV_B115200) ? DIV_MAX_A : DIV_B115200;
    localparam int DIV_W     = $clog2(DIV_MAX + 1);
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic             armed_q, armed_d;
    logic             arm_eff;
    logic             go;

    logic [7:0]       presc_q, presc_d;
    logic [7:0]       lp_div_q, lp_div_d;
    logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_sel_q, div_sel_d;
    logic [DIV_W-1:0] baud_div;
    logic             bit_tick;
    logic             bit_done;
    logic             frame_done;

    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;

    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             txf_q, txf_d;
    logic             int_q, int_d;
    logic             ovf_q, ovf_d;

    assign fifo_head  = mem_q[rd_ptr_q];
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // A full FIFO rejects the write even when a pop frees a slot this cycle.
    assign push = wdata_valid && !fifo_full;

    // The arm strobe launches in the same cycle it arrives, so txd drops on
    // the very next edge rather than waiting for armed_q to register.
    assign arm_eff = armed_q || (ctrl_txst && ctrl_txen);
    assign go      = arm_eff && ctrl_txen && !fifo_empty;

    assign bit_tick   = (presc_q == lp_div_q);
    assign bit_done   = bit_tick && (bit_cnt_q == div_sel_q - DIV_W'(1));
    assign frame_done = (state_q == STOP) && bit_done;
    assign pop        = go && ((state_q == IDLE) || frame_done);

    always_comb begin
        case (ctrl_baud)
            2'd1:    baud_div = DIV_W'(DIV_B38400);
            2'd2:    baud_div = DIV_W'(DIV_B115200);
            default: baud_div = DIV_W'(DIV_B9600);
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // A fresh arm strobe outranks the end-of-queue clear in the same cycle.
    always_comb begin
        armed_d = ctrl_txen && (ctrl_txst || (armed_q && !(frame_done && fifo_empty)));
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        lp_div_d  = lp_div_q;
        div_sel_d = div_sel_q;

        if (state_q != IDLE) begin
            if (bit_tick) begin
                presc_d   = '0;
                bit_cnt_d = bit_done ? '0 : bit_cnt_q + DIV_W'(1);
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Rate settings are captured only here, so mid-frame edits wait for the next launch.
        if (pop) begin
            state_d   = START;
            shift_d   = fifo_head;
            parity_d  = ^fifo_head;
            presc_d   = '0;
            bit_cnt_d = '0;
            bit_idx_d = '0;
            lp_div_d  = lpmode_en ? lpmode_div : 8'd0;
            div_sel_d = baud_div;
        end
    end

    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = parity_d;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        int_d  = frame_done;
        ovf_d  = wdata_valid && fifo_full;
        txf_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            armed_q   <= 1'b0;
            presc_q   <= '0;
            lp_div_q  <= '0;
            bit_cnt_q <= '0;
            div_sel_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            txf_q     <= 1'b0;
            int_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            armed_q   <= armed_d;
            presc_q   <= presc_d;
            lp_div_q  <= lp_div_d;
            bit_cnt_q <= bit_cnt_d;
            div_sel_q <= div_sel_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            txf_q     <= txf_d;
            int_q     <= int_d;
            ovf_q     <= ovf_d;
        end
    end

    assign txd        = txd_q;
    assign stat_busy  = busy_q;
    assign stat_txf   = txf_q;
    assign intstat_tx = int_q;
    assign tx_ovf     = ovf_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side controller for the UART register map.
- Buffers bytes written to DATA.FIFO in a small TX FIFO and generates the bit clock from CTRL.BAUD and LPMODE.DIV/EN.
- Sequences each frame: start, 8 data bits, optional parity, stop.
- Drives STAT.BUSY, STAT.TXF and INTSTAT.TX back into the regmap; sits between the generated register block and the TXD pad.

Parameters:
- DEPTH, 4, TX FIFO entries; power of two, 2..16.
- DIV_B9600, 5208, clocks per bit when ctrl_baud=0 or 3 (3 is reserved).
- DIV_B38400, 1302, clocks per bit when ctrl_baud=1.
- DIV_B115200, 434, clocks per bit when ctrl_baud=2.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active high.
- wdata_valid  in  1  one-cycle strobe: DATA register write.
- wdata  in  8  DATA.FIFO write value.
- ctrl_baud  in  2  CTRL.BAUD.
- ctrl_txen  in  1  CTRL.TXEN, transmitter enable level.
- ctrl_txst  in  1  CTRL.TXST one-cycle strobe: arm transmission.
- lpmode_en  in  1  LPMODE.EN.
- lpmode_div  in  8  LPMODE.DIV.
- txd  out  1  serial output, idle high.
- stat_busy  out  1  STAT.BUSY.
- stat_txf  out  1  STAT.TXF, FIFO full.
- intstat_tx  out  1  INTSTAT.TX set pulse, one cycle.
- tx_ovf  out  1  one-cycle pulse: write dropped.

Behaviour:
- Reset state (async, immediate): txd=1, stat_busy=0, stat_txf=0, intstat_tx=0, tx_ovf=0, FIFO empty, armed=0, FSM=IDLE, all counters 0.
- FIFO write:
  - wdata_valid with count<DEPTH pushes wdata.
  - wdata_valid with count==DEPTH is dropped and pulses tx_ovf the next cycle. This holds even if a pop occurs in the same cycle.
  - stat_txf = (count==DEPTH), registered.
- Arm flag:
  - Set by ctrl_txst while ctrl_txen=1; ctrl_txst is ignored while ctrl_txen=0.
  - Cleared when ctrl_txen=0.
  - Cleared when a frame finishes with the FIFO empty.
- Launch condition (go) = armed & ctrl_txen & FIFO non-empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on go, pop FIFO head into shift register, sample bit period, enter START. txd goes 0 on the next clock edge (1 cycle latency from go).
  - START: 1 bit period, txd=0 -> DATA.
  - DATA: 8 bit periods, LSB first -> PARITY if PARITY_EN, else STOP.
  - PARITY: 1 bit period, txd = XOR of the 8 data bits (even parity) -> STOP.
  - STOP: 1 bit period, txd=1. In its last cycle: pulse intstat_tx; if go, pop and go to START (back-to-back, no idle cycle), else go to IDLE.
- Bit period:
  - P = DIV_sel * (lpmode_en ? lpmode_div+1 : 1) clocks.
  - ctrl_baud, lpmode_en and lpmode_div are sampled at frame launch only; changes mid-frame take effect on the next frame.
  - Implementation: prescaler counter 0..lpmode_div produces an enable; bit counter counts enabled cycles 0..DIV_sel-1.
  - Counters are wide enough for DIV_B9600*256 with no wrap.
- Frame length = (10 + PARITY_EN) * P clocks.
- ctrl_txen deasserted mid-frame: current frame completes normally, no new frame launches, FIFO contents are retained.
- stat_busy = (FSM != IDLE), registered with txd.
- Reset mid-frame: frame aborted, txd=1 at once, FIFO flushed.

Test Plan:
- DIV_B115200=4, PARITY_EN=1, baud=2; write 0xA5, txst -> txd low 1 cycle after txst for 4 clks; then bits 1,0,1,0,0,1,0,1 at 4 clks each; parity 0; stop 1. Busy high for 44 clks; intstat_tx pulses on clk 44.
- DEPTH=4; 5 consecutive writes with txen=0 -> stat_txf=1 after 4th write, tx_ovf pulse on 5th. Then txen=1 + txst -> 4 frames back-to-back with txd never idling between stop and start, 4 intstat_tx pulses, stat_txf=0 after first pop.
- lpmode_en=1, lpmode_div=2, baud=2 (DIV 4) -> each bit 12 clks, frame 132 clks.
- Two queued bytes, baud switched 2->1 (DIV 4->8) during frame 1 -> frame 1 stays 44 clks, frame 2 is 88 clks.
- txen cleared during DATA of frame 1 with 1 byte queued -> frame 1 completes and busy falls, second byte stays queued. txen=1 + txst -> second frame sent.
- rst pulsed during DATA bit 3 -> txd=1, stat_busy=0, stat_txf=0 in the same cycle, no intstat_tx. After release, a new txst with an empty FIFO produces no activity.
